data_memory_responder: RTL and testbench
========================================

# data_memory_responder

Memory-side responder for the pipelined processor's data bus. Accepts one request per cycle on the processor's `Daddress`/`Dout`/`W` outputs and returns read data on the processor's `DataIn` input one cycle later. Holds a word-addressed single-port RAM that is zero-cleared by a post-reset sweep state machine. Flags and counts out-of-range accesses. Sits at top level beside the processor, between its memory ports and the RAM.

## Interface

- `ADDR_BITS`, 8: RAM index width; depth = 2^ADDR_BITS words.
- `WORD_W`, 20: data word width. Must match the processor bus.

- `Clock` input 1: single clock, rising-edge.
- `Reset` input 1: asynchronous, active-high.
- `Daddress` input 20: request address (word address), from the processor.
- `Dout` input 20: write data, from the processor.
- `W` input 1: 1 = write request, 0 = read request.
- `DataIn` output 20: response data, to the processor.
- `Ready` output 1: 1 once the clear sweep has finished and requests are serviced.
- `AddrError` output 1: sticky; set by any serviced out-of-range request.
- `ErrorCount` output 8: saturating count of out-of-range requests.

## Operation

- States:
  - CLEAR: post-reset zero sweep.
  - READY: servicing requests.
- Reset asserted, at any time including mid-sweep or mid-operation:
  - state CLEAR, sweep counter 0.
  - `DataIn`=0, `Ready`=0, `AddrError`=0, `ErrorCount`=0.
  - RAM contents are not touched by reset itself. The sweep re-zeroes them.
- CLEAR behaviour:
  - Each edge writes 0 to `mem[cnt]` and increments `cnt`.
  - After writing index 2^ADDR_BITS−1, the state moves to READY on that same edge.
  - All requests are ignored during CLEAR: `W` has no effect, `DataIn` holds 0, and errors are not counted.
- READY, in-range request (`Daddress[19:ADDR_BITS]` == 0), index = `Daddress[ADDR_BITS-1:0]`:
  - Write: `mem[index]` <= `Dout`, and `DataIn` <= `Dout` (write-first echo).
  - Read: `DataIn` <= `mem[index]`.
- READY, out-of-range request:
  - Write is dropped.
  - `DataIn` <= 0.
  - `AddrError` <= 1.
  - `ErrorCount` <= `ErrorCount`+1, saturating at 255.
- Back-to-back write then read of the same index returns the new data. The RAM update precedes the next cycle's read.
- `AddrError` clears only on `Reset`.

## Timing

- Read latency is 1 cycle: a request sampled at edge N produces `DataIn` valid after edge N, usable during cycle N+1.
- No stall or handshake toward the processor. One request is accepted per cycle in READY.
- The clear sweep takes exactly 2^ADDR_BITS edges after `Reset` deasserts. `Ready` rises after edge 2^ADDR_BITS (256 with defaults).
- `Ready`, `DataIn`, `AddrError` and `ErrorCount` are all registered outputs, with no combinational path from any input.
- Error-count saturation: at 255, further errors leave the count at 255. There is no wrap-around.

## Structure

- Shared package contents:
  - `WORD_W`, default `ADDR_BITS`.
  - State enum {CLEAR, READY}.
  - `ERRCNT_W`=8 and `ERRCNT_MAX`=255.
- Sub-module `memory_array_sp`: single-port synchronous RAM (we, addr, wdata, rdata registered).
  - The responder muxes the sweep address and data onto it during CLEAR.
- Remaining logic lives in the top: FSM, sweep counter, range check, error logic, `DataIn` mux (echo / rdata / zero).

## Test plan

- Reset sweep: release `Reset`.
  - `Ready`=0 for 256 edges, then 1.
  - Reads of addresses 0x00000, 0x0007F and 0x000FF all return 0.
- Write/read: write 0xABCDE to 0x00012, then read 0x00012 on the next cycle.
  - `DataIn`=0xABCDE after the write edge (echo) and again after the read edge.
- Out of range: write 0x12345 to 0x00100, then read 0x00000.
  - `DataIn`=0 after the write edge.
  - `AddrError`=1, `ErrorCount`=1.
  - Read of 0x00000 still returns 0.
- Saturation: issue 300 out-of-range reads.
  - `ErrorCount`=255.
  - `AddrError` stays 1.
- Reset mid-operation: write 0x55555 to 0x00003, assert `Reset` mid-cycle, release it, then wait 256 edges.
  - All outputs are 0 immediately on `Reset` assertion.
  - `Ready` returns to 1 after the sweep.
  - Read of 0x00003 returns 0.
- Requests during CLEAR: drive `W`=1 to 0x00005 with 0x0F0F0 during the sweep.
  - No error is counted.
  - After `Ready`, a read of 0x00005 returns 0.

Source files
------------

// File: rtl/data_memory_responder_pkg.sv
// Shared constants and types for the data-bus memory responder.
// Holds the bus width, the default RAM index width, the state encoding and the error counter.
package data_memory_responder_pkg;

   localparam int unsigned WORD_W        = 20;
   localparam int unsigned DEF_ADDR_BITS = 8;
   localparam int unsigned ERRCNT_W      = 8;

   localparam logic [ERRCNT_W-1:0] ERRCNT_MAX = ERRCNT_W'(255);

   typedef enum logic {
      CLEAR,
      READY
   } state_e;

   // Selects which source drives the registered response word.
   typedef enum logic [1:0] {
      SEL_ZERO,
      SEL_ECHO,
      SEL_RDATA
   } rsel_e;

   // Counter increment that sticks at ERRCNT_MAX instead of wrapping.
   function automatic logic [ERRCNT_W-1:0] sat_inc(input logic [ERRCNT_W-1:0] value);
      return (value == ERRCNT_MAX) ? value : value + ERRCNT_W'(1);
   endfunction

endpackage

// File: rtl/data_memory_responder_memory_array_sp.sv
// Single-port synchronous RAM with a registered read port.
// A read in the same cycle as a write returns the previous contents.
module memory_array_sp #(
   parameter int unsigned ADDR_BITS = 8,
   parameter int unsigned WORD_W    = 20
) (
   input  logic                 clk,
   input  logic                 we,
   input  logic [ADDR_BITS-1:0] addr,
   input  logic [WORD_W-1:0]    wdata,
   output logic [WORD_W-1:0]    rdata
);

   logic [WORD_W-1:0] mem [2**ADDR_BITS];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      rdata <= mem[addr];
   end

endmodule

// File: rtl/data_memory_responder.sv
// Memory-side responder for the processor data bus: zero-clear sweep after reset,
// then one read or write per cycle with a one-cycle response and out-of-range error tracking.
module data_memory_responder #(
   parameter int unsigned ADDR_BITS = data_memory_responder_pkg::DEF_ADDR_BITS,
   parameter int unsigned WORD_W    = data_memory_responder_pkg::WORD_W
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic [WORD_W-1:0] Daddress,
   input  logic [WORD_W-1:0] Dout,
   input  logic              W,
   output logic [WORD_W-1:0] DataIn,
   output logic              Ready,
   output logic              AddrError,
   output logic [7:0]        ErrorCount
);

   import data_memory_responder_pkg::*;

   localparam logic [ADDR_BITS-1:0] LAST_IDX = '1;

   state_e                state;
   state_e                next_state;
   logic [ADDR_BITS-1:0]  cnt;
   logic [ADDR_BITS-1:0]  next_cnt;
   rsel_e                 sel;
   rsel_e                 next_sel;
   logic [WORD_W-1:0]     echo;
   logic [WORD_W-1:0]     next_echo;
   logic                  err_hit;
   logic                  in_range;

   logic                  ram_we;
   logic [ADDR_BITS-1:0]  ram_addr;
   logic [WORD_W-1:0]     ram_wdata;
   logic [WORD_W-1:0]     ram_rdata;

   assign in_range = ((Daddress >> ADDR_BITS) == '0);

   memory_array_sp #(
      .ADDR_BITS (ADDR_BITS),
      .WORD_W    (WORD_W)
   ) u_ram (
      .clk   (Clock),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (ram_rdata)
   );

   // Sweep owns the RAM port during CLEAR; afterwards the processor request does.
   always_comb begin
      next_state = state;
      next_cnt   = cnt;
      next_sel   = SEL_ZERO;
      next_echo  = echo;
      err_hit    = 1'b0;
      ram_we     = 1'b0;
      ram_addr   = Daddress[ADDR_BITS-1:0];
      ram_wdata  = Dout;

      case (state)
         CLEAR: begin
            ram_we    = 1'b1;
            ram_addr  = cnt;
            ram_wdata = '0;
            next_cnt  = cnt + ADDR_BITS'(1);
            if (cnt == LAST_IDX) begin
               next_state = READY;
            end
         end
         READY: begin
            if (!in_range) begin
               err_hit = 1'b1;
            end else if (W) begin
               ram_we    = 1'b1;
               next_sel  = SEL_ECHO;
               next_echo = Dout;
            end else begin
               next_sel = SEL_RDATA;
            end
         end
         default: begin
            next_state = CLEAR;
         end
      endcase
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state      <= CLEAR;
         cnt        <= '0;
         sel        <= SEL_ZERO;
         echo       <= '0;
         Ready      <= 1'b0;
         AddrError  <= 1'b0;
         ErrorCount <= '0;
      end else begin
         state <= next_state;
         cnt   <= next_cnt;
         sel   <= next_sel;
         echo  <= next_echo;
         Ready <= (next_state == READY);
         if (err_hit) begin
            AddrError  <= 1'b1;
            ErrorCount <= sat_inc(ErrorCount);
         end
      end
   end

   // Response word is picked from registered sources only; the RAM read port is not reset.
   always_comb begin
      DataIn = '0;
      case (sel)
         SEL_ECHO:  DataIn = echo;
         SEL_RDATA: DataIn = ram_rdata;
         default:   DataIn = '0;
      endcase
   end

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: behavioural model checked every cycle, plus literal spot checks.
module tb_data_memory_responder;

   localparam int unsigned AB    = 8;
   localparam int unsigned WW    = 20;
   localparam int unsigned DEPTH = 256;

   logic          Clock = 1'b0;
   logic          Reset;
   logic          W;
   logic [19:0]   Daddress;
   logic [19:0]   Dout;
   logic [19:0]   DataIn;
   logic          Ready;
   logic          AddrError;
   logic [7:0]    ErrorCount;

   int vectors     = 0;
   int miscompares = 0;
   bit chk_en      = 1'b0;

   data_memory_responder #(
      .ADDR_BITS (AB),
      .WORD_W    (WW)
   ) dut (
      .Clock      (Clock),
      .Reset      (Reset),
      .Daddress   (Daddress),
      .Dout       (Dout),
      .W          (W),
      .DataIn     (DataIn),
      .Ready      (Ready),
      .AddrError  (AddrError),
      .ErrorCount (ErrorCount)
   );

   always #5 Clock = ~Clock;

   // Model: memory as an array, ready after DEPTH clean edges, errors as a plain saturating int.
   logic [19:0] m_mem [DEPTH];
   logic [19:0] m_data  = '0;
   logic        m_ready = 1'b0;
   logic        m_err   = 1'b0;
   int          m_cnt   = 0;
   int          m_edges = 0;

   always @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         m_data  = '0;
         m_ready = 1'b0;
         m_err   = 1'b0;
         m_cnt   = 0;
         m_edges = 0;
      end else if (!m_ready) begin
         m_edges++;
         m_data = '0;
         if (m_edges == DEPTH) begin
            m_ready = 1'b1;
            foreach (m_mem[i]) m_mem[i] = '0;
         end
      end else if (Daddress < DEPTH) begin
         if (W) begin
            m_mem[Daddress[7:0]] = Dout;
            m_data = Dout;
         end else begin
            m_data = m_mem[Daddress[7:0]];
         end
      end else begin
         m_data = '0;
         m_err  = 1'b1;
         if (m_cnt < 255) m_cnt++;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge Clock) begin
      if (chk_en && !Reset) begin
         check("DataIn",     32'(DataIn),     32'(m_data));
         check("Ready",      32'(Ready),      32'(m_ready));
         check("AddrError",  32'(AddrError),  32'(m_err));
         check("ErrorCount", 32'(ErrorCount), 32'(m_cnt));
      end
   end

   task automatic step(input logic w, input logic [19:0] a, input logic [19:0] d);
      @(negedge Clock);
      W        = w;
      Daddress = a;
      Dout     = d;
   endtask

   // Release reset, keep requesting writes/out-of-range accesses during the sweep, time Ready.
   task automatic sweep();
      int n;
      n = 0;
      @(negedge Clock);
      Reset    = 1'b0;
      W        = 1'b1;
      Daddress = 20'h00005;
      Dout     = 20'h0F0F0;
      while (!Ready && n < 400) begin
         @(negedge Clock);
         n++;
         Daddress = (n % 2 == 1) ? 20'h00100 : 20'h00005;
      end
      check("ready_edges", 32'(n), 32'd256);
      check("clear_no_err", 32'(ErrorCount), 32'd0);
      W        = 1'b0;
      Daddress = '0;
      Dout     = '0;
   endtask

   initial begin
      Reset    = 1'b1;
      W        = 1'b0;
      Daddress = '0;
      Dout     = '0;
      repeat (3) @(negedge Clock);
      chk_en = 1'b1;
      check("rst_DataIn", 32'(DataIn), 32'd0);
      check("rst_Ready",  32'(Ready),  32'd0);
      check("rst_Err",    32'(AddrError), 32'd0);
      check("rst_Cnt",    32'(ErrorCount), 32'd0);

      sweep();

      step(1'b0, 20'h00000, '0);
      step(1'b0, 20'h0007F, '0);
      check("rd_00000", 32'(DataIn), 32'd0);
      step(1'b0, 20'h000FF, '0);
      check("rd_0007F", 32'(DataIn), 32'd0);
      step(1'b0, 20'h00005, '0);
      check("rd_000FF", 32'(DataIn), 32'd0);
      step(1'b1, 20'h00012, 20'hABCDE);
      check("rd_00005_clear_write", 32'(DataIn), 32'd0);
      step(1'b0, 20'h00012, '0);
      check("wr_echo", 32'(DataIn), 32'h000ABCDE);
      step(1'b1, 20'h00100, 20'h12345);
      check("rd_after_wr", 32'(DataIn), 32'h000ABCDE);
      step(1'b0, 20'h00000, '0);
      check("oor_data", 32'(DataIn), 32'd0);
      check("oor_flag", 32'(AddrError), 32'd1);
      check("oor_cnt",  32'(ErrorCount), 32'd1);
      step(1'b0, 20'h00012, '0);
      check("rd_00000_after_oor", 32'(DataIn), 32'd0);

      for (int i = 0; i < 300; i++) begin
         step(1'b0, 20'(32'h100 + i), '0);
      end
      step(1'b0, 20'h00000, '0);
      check("sat_cnt",  32'(ErrorCount), 32'd255);
      check("sat_flag", 32'(AddrError), 32'd1);

      step(1'b1, 20'h00003, 20'h55555);
      @(posedge Clock);
      #2 Reset = 1'b1;
      #1;
      check("midrst_DataIn", 32'(DataIn), 32'd0);
      check("midrst_Ready",  32'(Ready), 32'd0);
      check("midrst_Err",    32'(AddrError), 32'd0);
      check("midrst_Cnt",    32'(ErrorCount), 32'd0);
      W        = 1'b0;
      Daddress = '0;

      sweep();

      step(1'b0, 20'h00003, '0);
      step(1'b0, 20'h00005, '0);
      check("rd_00003_after_reset", 32'(DataIn), 32'd0);
      step(1'b0, 20'h00000, '0);
      check("rd_00005_after_reset", 32'(DataIn), 32'd0);
      check("post_reset_cnt",  32'(ErrorCount), 32'd0);
      check("post_reset_flag", 32'(AddrError), 32'd0);
      step(1'b0, 20'h00000, '0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
